// File: rtl/dmem_pkg.sv
// Shared definitions for the data_mem access path: FSM states, funct3 codes,
// data_mem sign_mask encodings and response error codes.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // bit3 = sign-extend, bits2:0 = lane mask
  localparam logic [3:0] SM_B_SX = 4'b1001;
  localparam logic [3:0] SM_H_SX = 4'b1011;
  localparam logic [3:0] SM_W    = 4'b0111;
  localparam logic [3:0] SM_B_ZX = 4'b0001;
  localparam logic [3:0] SM_H_ZX = 4'b0011;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_FUNCT3   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/dmem_mask_enc.sv
// Combinational funct3 -> sign_mask encoder with legality and alignment checks.
// Shared with the decoder so exceptions can be flagged early.
module dmem_mask_enc
  import dmem_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       illegal,
  output logic       misaligned
);

  always_comb begin
    sign_mask = '0;
    illegal   = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    sign_mask = SM_B_ZX;
        F3_H:    sign_mask = SM_H_ZX;
        F3_W:    sign_mask = SM_W;
        default: illegal   = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    sign_mask = SM_B_SX;
        F3_H:    sign_mask = SM_H_SX;
        F3_W:    sign_mask = SM_W;
        F3_BU:   sign_mask = SM_B_ZX;
        F3_HU:   sign_mask = SM_H_ZX;
        default: illegal   = 1'b1;
      endcase
    end
  end

  // An illegal funct3 is never also reported as misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (!illegal) begin
      case (funct3[1:0])
        2'b01:   misaligned = addr_lo[0];
        2'b10:   misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage initiator for the data_mem port: one request at a time, one-cycle
// strobe, waits out clk_stall (with optional timeout), then returns a response.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_code,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  dmem_state_t      state;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       enc_mask;
  logic             enc_illegal;
  logic             enc_misaligned;

  dmem_mask_enc u_mask_enc (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .sign_mask  (enc_mask),
    .illegal    (enc_illegal),
    .misaligned (enc_misaligned)
  );

  assign req_ready = (state == ST_IDLE);
  assign cnt_inc   = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      we_q           <= 1'b0;
      cnt            <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      resp_err_code  <= ERR_NONE;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            mem_sign_mask  <= enc_mask;
            we_q           <= req_we;
            if (enc_illegal || enc_misaligned) begin
              resp_valid    <= 1'b1;
              resp_err      <= 1'b1;
              resp_err_code <= enc_illegal ? ERR_FUNCT3 : ERR_MISALIGN;
              resp_rdata    <= '0;
              state         <= ST_RESP;
            end else begin
              mem_memread  <= ~req_we;
              mem_memwrite <= req_we;
              state        <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mem_memread  <= 1'b0;
          mem_memwrite <= 1'b0;
          state        <= ST_SETTLE;
        end
        ST_SETTLE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem_clk_stall) begin
            resp_rdata    <= we_q ? '0 : mem_read_data;
            resp_err      <= 1'b0;
            resp_err_code <= ERR_NONE;
            resp_valid    <= 1'b1;
            state         <= ST_RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
            // The stalled cycle being counted here is itself the TIMEOUT_CYCLES-th.
            resp_rdata    <= '0;
            resp_err      <= 1'b1;
            resp_err_code <= ERR_TIMEOUT;
            resp_valid    <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          mem_memread  <= 1'b0;
          mem_memwrite <= 1'b0;
          resp_valid   <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, randomized
// transactions against a rule-level model, plus reset-in-flight and backpressure.
module tb_dmem_access_ctrl;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_err_code;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = '0;
  logic        mem_clk_stall = 1'b0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_err_code(resp_err_code),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdval;
    int unsigned stall;
    int unsigned hold;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [1:0]  exp_code;
    int unsigned exp_lat;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  // data_mem responder state: stall length and read value for the current access
  int unsigned cur_stall = 0;
  logic [31:0] cur_rd = '0;
  int unsigned stall_left = 0;
  int unsigned rd_strobes = 0;
  int unsigned wr_strobes = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_left    = 0;
      mem_clk_stall = 1'b0;
    end else begin
      if (mem_memread) rd_strobes++;
      if (mem_memwrite) wr_strobes++;
      // Stall rises during SETTLE and covers exactly cur_stall WAIT cycles.
      if ((mem_memread || mem_memwrite) && cur_stall > 0) stall_left = cur_stall + 2;
      mem_clk_stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      mem_read_data = mem_clk_stall ? $urandom : cur_rd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour derived from access size, legality and stall length.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdval,
                                 input int unsigned stall, input int unsigned hold);
    vec_t v;
    int unsigned bytes;
    bit legal;
    bit sx;
    bytes = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sx = !we && !f3[2] && bytes < 4;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdval = rdval;
    v.stall = stall; v.hold = hold;
    v.exp_mask = {sx, 3'(2 * bytes - 1)};
    v.exp_rdata = '0;
    v.exp_err = 1'b1;
    if (!legal) begin
      v.exp_code = 2'd2; v.exp_lat = 1;
    end else if ((addr % bytes) != 0) begin
      v.exp_code = 2'd1; v.exp_lat = 1;
    end else if (TO != 0 && stall >= TO) begin
      v.exp_code = 2'd3; v.exp_lat = 3 + TO;
    end else begin
      v.exp_err = 1'b0; v.exp_code = 2'd0; v.exp_lat = 4 + stall;
      v.exp_rdata = we ? 32'h0 : rdval;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat;
    int unsigned rd0, wr0, guard;
    bit busy_ready, unstable;
    logic [31:0] rdata0;
    logic [1:0] code0;
    guard = 0;
    while (stall_left != 0 && guard < 200) begin @(negedge clk); guard++; end
    @(negedge clk);
    cur_stall = v.stall; cur_rd = v.rdval;
    rd0 = rd_strobes; wr0 = wr_strobes;
    check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    lat = 1; busy_ready = 1'b0;
    while (!resp_valid && lat < 300) begin
      if (req_ready) busy_ready = 1'b1;
      req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1);
      req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, v.exp_lat);
    check({tag, ".rdata"}, resp_rdata, v.exp_rdata);
    check({tag, ".err"}, 32'(resp_err), 32'(v.exp_err));
    check({tag, ".code"}, 32'(resp_err_code), 32'(v.exp_code));
    check({tag, ".busy_ready"}, 32'(busy_ready | req_ready), 32'd0);
    check({tag, ".rd_strobes"}, rd_strobes - rd0, (!v.we && v.exp_code != 2'd1 && v.exp_code != 2'd2) ? 1 : 0);
    check({tag, ".wr_strobes"}, wr_strobes - wr0, (v.we && v.exp_code != 2'd1 && v.exp_code != 2'd2) ? 1 : 0);
    check({tag, ".mem_addr"}, mem_addr, v.addr);
    check({tag, ".mem_wdata"}, mem_write_data, v.wdata);
    if (v.exp_code != 2'd2) check({tag, ".sign_mask"}, 32'(mem_sign_mask), 32'(v.exp_mask));
    rdata0 = resp_rdata; code0 = resp_err_code; unstable = 1'b0;
    for (int unsigned i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || resp_rdata !== rdata0 || resp_err_code !== code0) unstable = 1'b1;
    end
    if (v.hold > 0) check({tag, ".resp_hold_stable"}, 32'(unstable), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    check({tag, ".post_hs_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".post_hs_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".resp_fields"}, {resp_rdata[29:0], resp_err, 1'b0} | 32'(resp_err_code), 32'd0);
    check({tag, ".strobes"}, {30'd0, mem_memread, mem_memwrite}, 32'd0);
    check({tag, ".mem_addr"}, mem_addr, 32'd0);
    check({tag, ".mem_wdata"}, mem_write_data, 32'd0);
    check({tag, ".sign_mask"}, 32'(mem_sign_mask), 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdval,
                              input int unsigned stall, input int unsigned hold,
                              input logic [3:0] mask, input logic [31:0] rdata,
                              input logic err, input logic [1:0] code, input int unsigned lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdval = rdval;
    v.stall = stall; v.hold = hold; v.exp_mask = mask; v.exp_rdata = rdata;
    v.exp_err = err; v.exp_code = code; v.exp_lat = lat;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    tbl[0]  = mk(1, 3'b000, 32'h400, 32'hAAA, 32'h1234_5678, 0,  0, 4'b0001, 32'h0, 0, 2'd0, 4);
    tbl[1]  = mk(0, 3'b000, 32'h400, 32'h0, 32'hFFFF_FFAA, 10, 0, 4'b1001, 32'hFFFF_FFAA, 0, 2'd0, 14);
    tbl[2]  = mk(0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 4'b1011, 32'h0, 1, 2'd1, 1);
    tbl[3]  = mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1, 2'd2, 1);
    tbl[4]  = mk(0, 3'b010, 32'h40, 32'h0, 32'hAAAA_AAAA, 0, 5, 4'b0111, 32'hAAAA_AAAA, 0, 2'd0, 4);
    tbl[5]  = mk(1, 3'b010, 32'h3, 32'h5555, 32'h0, 0, 0, 4'b0111, 32'h0, 1, 2'd1, 1);
    tbl[6]  = mk(1, 3'b100, 32'h8, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1, 2'd2, 1);
    tbl[7]  = mk(0, 3'b101, 32'h102, 32'h0, 32'h0000_BEEF, 2, 1, 4'b0011, 32'h0000_BEEF, 0, 2'd0, 6);
    tbl[8]  = mk(1, 3'b011, 32'h7, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1, 2'd2, 1);
    tbl[9]  = mk(1, 3'b001, 32'h2, 32'hBEEF, 32'h0, 1, 0, 4'b0011, 32'h0, 0, 2'd0, 5);
    tbl[10] = mk(0, 3'b010, 32'h80, 32'h0, 32'h1111_2222, 63, 0, 4'b0111, 32'h1111_2222, 0, 2'd0, 67);
    tbl[11] = mk(0, 3'b010, 32'h80, 32'h0, 32'h3333_4444, 64, 0, 4'b0111, 32'h0, 1, 2'd3, 67);
    tbl[12] = mk(0, 3'b100, 32'h3, 32'h0, 32'h0000_0080, 0, 0, 4'b0001, 32'h0000_0080, 0, 2'd0, 4);

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 120; i++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      int unsigned st;
      we = 1'($urandom);
      f3 = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      st = ($urandom_range(0, 9) == 0) ? $urandom_range(62, 66) : $urandom_range(0, 4);
      run_vec(model(we, f3, addr, $urandom, $urandom, st, $urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    // Reset pulled in the middle of a stalled WAIT: no response may follow.
    @(negedge clk);
    cur_stall = 20; cur_rd = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (4) begin @(negedge clk); if (resp_valid || mem_memread) seen = 1'b1; end
      check("mid_reset.no_resp", 32'(seen), 32'd0);
    end
    run_vec(model(0, 3'b000, 32'h401, 32'h0, 32'hFFFF_FF80, 3, 0), "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Pipeline-side initiator for the data_mem (cache) port; the data_mem is the responder.
- Accepts one load/store request at a time over a valid/ready handshake and encodes RISC-V funct3 into data_mem's sign_mask.
- Issues a one-cycle memread/memwrite strobe, waits out clk_stall, then returns read data or an error over a valid/ready response channel.
- Sits between the MEM stage and data_mem.

Parameters:
- TIMEOUT_CYCLES, 64, max WAIT cycles with clk_stall high before an error is reported; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (only clock domain).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  32  load result, already extended by data_mem; 0 for stores and errors.
- resp_err  out  1  request failed.
- resp_err_code  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout.
- mem_addr  out  32  to data_mem addr.
- mem_write_data  out  32  to data_mem write_data.
- mem_memwrite  out  1  to data_mem memwrite.
- mem_memread  out  1  to data_mem memread.
- mem_sign_mask  out  4  to data_mem sign_mask.
- mem_read_data  in  32  from data_mem read_data.
- mem_clk_stall  in  1  from data_mem clk_stall.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - State IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_err_code=0; resp_rdata=0.
  - mem_memread=0; mem_memwrite=0; mem_addr=0; mem_write_data=0; mem_sign_mask=0; timeout counter=0.
- sign_mask encoding (bit3 = sign-extend, bits2:0 = lane mask):
  - Loads: LB 000→1001, LH 001→1011, LW 010→0111, LBU 100→0001, LHU 101→0011.
  - Stores: SB 000→0001, SH 001→0011, SW 010→0111.
  - Any other funct3/we combination is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Illegal funct3 takes priority over misalignment.
- Every output except req_ready is registered. req_ready = (state==IDLE).
- mem_addr, mem_write_data and mem_sign_mask load at accept and hold their last value until the next accept. They never glitch during a transaction.
- IDLE:
  - On accept, latch the request.
  - If illegal or misaligned → RESP with resp_err=1 and the matching code; no strobe is issued.
  - Otherwise → ISSUE.
- ISSUE: exactly one cycle with mem_memread=~we, mem_memwrite=we → SETTLE.
- SETTLE: one cycle with strobes low, giving data_mem time to raise clk_stall → WAIT. Counter cleared.
- WAIT:
  - If mem_clk_stall=0: capture mem_read_data for loads (0 for stores) → RESP, no error.
  - Else increment the counter. When counter==TIMEOUT_CYCLES (and non-zero) → RESP with err code 3 and rdata 0.
- RESP:
  - resp_valid=1; rdata, err and code held stable.
  - On resp_ready → IDLE, resp_valid=0 next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency (accept in cycle N, data_mem never stalls): resp_valid rises in cycle N+4. Error path: resp_valid rises in cycle N+1.
- Throughput: at most one outstanding request; minimum 5 cycles per successful access.
- Reset mid-operation: returns to IDLE immediately and strobes drop. An in-flight data_mem operation completes unobserved; no response is produced.
- req_valid with an x/unchanged request while not in IDLE is ignored.

Decomposition:
- Shared package/include dmem_pkg:
  - state encodings (IDLE, ISSUE, SETTLE, WAIT, RESP);
  - funct3 constants;
  - the five sign_mask constants;
  - error-code constants.
- One combinational sub-module, dmem_mask_enc:
  - inputs (we, funct3, addr[1:0]);
  - outputs (sign_mask, illegal, misaligned).
  - Reused by the instruction decoder for early exception checks.

Test Plan:
- SB addr 0x400 wdata 0xAAA, no stall → mem_sign_mask=0001, mem_memwrite high exactly 1 cycle, resp_valid at N+4, rdata 0, err 0.
- LB 0x400 with mem_read_data=0xFFFFFFAA, clk_stall high 10 cycles after SETTLE → mem_sign_mask=1001, mem_memread one cycle, resp_rdata 0xFFFFFFAA when the stall drops.
- LH 0x101 → resp_err=1, code 1 at N+1, no strobe; funct3=011 load → code 2 at N+1.
- clk_stall held high, TIMEOUT_CYCLES=64 → resp_err code 3 after 64 WAIT cycles; strobe was issued once.
- LW 0x40 with mem_read_data=0xAAAAAAAA, resp_ready low 5 cycles → resp_valid and rdata stable, req_ready 0 throughout; IDLE follows the handshake.
- rst_n pulled low during WAIT → all outputs at reset values asynchronously; next request after release completes normally.
